// File: rtl/debounce_ev_if.sv
// Purpose : carries one debounced press/release event from the scanner to its consumer.
// Latency : n/a (wires only).
// Backpressure: EvValid/EvReady handshake; the producer holds EvCh/EvRise while EvReady=0.
//
// Ports (modport master = producer, slave = consumer):
//   EvValid  event present
//   EvReady  consumer accepts the event this cycle
//   EvCh     channel index of the event
//   EvRise   1 = press (0->1), 0 = release (1->0)
interface debounce_ev_if #(
  parameter int IW = 2
);
  logic          EvValid;
  logic          EvReady;
  logic [IW-1:0] EvCh;
  logic          EvRise;

  modport master (
    output EvValid,
    output EvCh,
    output EvRise,
    input  EvReady
  );

  modport slave (
    input  EvValid,
    input  EvCh,
    input  EvRise,
    output EvReady
  );
endinterface

// File: rtl/debounce_scan_ctrl.sv
// Purpose : round-robin debouncer sharing one compare/count datapath across NCH switch inputs.
// Latency : 2-cycle synchronizer, then flip on the STABLE-th consecutive differing visit (<= 2 + STABLE*NCH cycles).
// Backpressure: a pending event parks the scanner in WAIT until EvReady; nothing is dropped.
//
// Ports:
//   Clk1ms   1 ms scan clock          RstN     async active-low reset
//   SwIn     raw switch levels        Enable   1 = scanning runs
//   SwOutDB  debounced levels         ScanIdx  channel visited next (debug)
//   ev       event handshake (debounce_ev_if.master)
module debounce_scan_ctrl #(
  parameter int NCH    = 4,
  parameter int STABLE = 4,
  parameter int CW     = 3,
  parameter int IW     = 2
) (
  input  logic            Clk1ms,
  input  logic            RstN,
  input  logic [NCH-1:0]  SwIn,
  input  logic            Enable,
  output logic [NCH-1:0]  SwOutDB,
  output logic [IW-1:0]   ScanIdx,
  debounce_ev_if.master   ev
);

  typedef enum logic {
    SCAN = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  state_t          state_q, state_d;
  logic [NCH-1:0]  sync1_q;
  logic [NCH-1:0]  sync_q;
  logic [NCH-1:0]  db_q, db_d;
  logic [CW-1:0]   cnt_q [NCH];
  logic [CW-1:0]   cnt_d [NCH];
  logic [IW-1:0]   idx_q, idx_d;
  logic            ev_vld_q, ev_vld_d;
  logic [IW-1:0]   ev_ch_q, ev_ch_d;
  logic            ev_rise_q, ev_rise_d;

  logic            cur_sync;
  logic            cur_db;

  always_comb begin
    state_d   = state_q;
    db_d      = db_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    ev_vld_d  = ev_vld_q;
    ev_ch_d   = ev_ch_q;
    ev_rise_d = ev_rise_q;
    cur_sync  = sync_q[idx_q];
    cur_db    = db_q[idx_q];

    if (state_q == SCAN) begin
      if (Enable) begin
        if (cur_sync == cur_db) begin
          // Agreement on any visit restarts qualification.
          cnt_d[idx_q] = '0;
        end else if (cnt_q[idx_q] != CNT_MAX) begin
          cnt_d[idx_q] = cnt_q[idx_q] + CW'(1);
        end else begin
          db_d[idx_q] = cur_sync;
          cnt_d[idx_q] = '0;
          ev_vld_d    = 1'b1;
          ev_ch_d     = idx_q;
          ev_rise_d   = cur_sync;
          state_d     = WAIT;
        end
        // The index advances even on the flip cycle, so scanning resumes on the next channel.
        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
      end
    end else begin
      // Whole scanner stalls while the event is outstanding; Enable has no effect here.
      if (ev.EvReady) begin
        ev_vld_d = 1'b0;
        state_d  = SCAN;
      end
    end
  end

  always_ff @(posedge Clk1ms or negedge RstN) begin
    if (!RstN) begin
      state_q   <= SCAN;
      sync1_q   <= '0;
      sync_q    <= '0;
      db_q      <= '0;
      cnt_q     <= '{default: '0};
      idx_q     <= '0;
      ev_vld_q  <= 1'b0;
      ev_ch_q   <= '0;
      ev_rise_q <= 1'b0;
    end else begin
      // Synchronizer runs every cycle regardless of scanner state.
      sync1_q   <= SwIn;
      sync_q    <= sync1_q;
      state_q   <= state_d;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      ev_vld_q  <= ev_vld_d;
      ev_ch_q   <= ev_ch_d;
      ev_rise_q <= ev_rise_d;
    end
  end

  assign SwOutDB    = db_q;
  assign ScanIdx    = idx_q;
  assign ev.EvValid = ev_vld_q;
  assign ev.EvCh    = ev_ch_q;
  assign ev.EvRise  = ev_rise_q;

endmodule

// File: doc/debounce_scan_ctrl.md
Name: debounce_scan_ctrl

Overview:
Time-multiplexed debounce controller that shares one compare/count datapath among NCH raw switch inputs.
- Visits one channel per Clk1ms tick in round-robin order.
- Keeps a per-channel stability counter and a per-channel debounced state.
- On each debounced edge, emits a press/release event through a valid/ready handshake.
- Sits between the board switch pins and the user-logic consumers of debounced levels and edge events.

Parameters:
NCH, 4, number of switch channels (>=2; any value, not only powers of two)
STABLE, 4, consecutive differing visits required to flip a channel (1..2^CW)
CW, 3, width of each per-channel stability counter
IW, 2, channel-index width (must satisfy 2^IW >= NCH)

Ports:
Clk1ms  input  1  1 ms scan clock; all state changes on its rising edge
RstN  input  1  asynchronous, active-low reset
SwIn  input  NCH  raw, asynchronous, bouncing switch levels
Enable  input  1  1 = scanning runs; 0 = scanner frozen in SCAN
SwOutDB  output  NCH  debounced switch levels (registered)
EvValid  output  1  event present
EvReady  input  1  consumer accepts the event
EvCh  output  IW  channel index of the event
EvRise  output  1  1 = press (0->1), 0 = release (1->0)
ScanIdx  output  IW  channel the scanner visits next (debug)

Behaviour:
- Reset (RstN=0, asynchronous): SwOutDB=0, EvValid=0, EvCh=0, EvRise=0, ScanIdx=0, all counters 0, synchronizer flops 0, state=SCAN. Reset mid-event discards the pending event.
- Synchronizer: every SwIn bit passes through a 2-flop synchronizer (SwSync) on every cycle, regardless of state. All comparisons use SwSync.
- FSM has two states, SCAN and WAIT.
- SCAN with Enable=1 processes channel k=ScanIdx each cycle:
  - If SwSync[k]==SwOutDB[k]: Cnt[k]<=0.
  - Else if Cnt[k]!=STABLE-1: Cnt[k]<=Cnt[k]+1.
  - Else (the flip): SwOutDB[k]<=SwSync[k], Cnt[k]<=0, EvValid<=1, EvCh<=k, EvRise<=SwSync[k], state<=WAIT.
  - ScanIdx always advances: k==NCH-1 -> 0, otherwise k+1. This includes the flip cycle.
- SCAN with Enable=0: ScanIdx, all counters and SwOutDB hold. Synchronizers keep running.
- WAIT:
  - No channel is processed. ScanIdx, counters and SwOutDB hold, and Enable is ignored.
  - EvValid, EvCh and EvRise stay stable while EvReady=0.
  - On an edge with EvValid=1 and EvReady=1: EvValid<=0, state<=SCAN. Scanning resumes on the following cycle at the held ScanIdx.
  - No event is ever dropped or overwritten. Backpressure stalls the whole scanner.
- Flip timing: the flip happens on the STABLE-th consecutive visit at which the channel differs. Any visit where it agrees clears the count, so a bounce restarts qualification.
- Latency from a clean raw change to the flip: at most 2 + STABLE*NCH cycles with no stall. With NCH=4 and STABLE=4 that is at most 18 cycles.
- STABLE=1: a channel flips on its first differing visit. Counters then stay 0.
- Counter arithmetic is unsigned CW-bit. A counter never exceeds STABLE-1 and never wraps.
- Only the visited channel's counter changes in any cycle. SwOutDB changes on at most one bit per cycle.

Test Plan:
1. Reset, then SwIn=4'b0000 held for 40 cycles -> SwOutDB=0, EvValid never asserts, ScanIdx cycles 0,1,2,3,0...
2. EvReady=1, SwIn[2] 0->1 held clean -> SwOutDB[2]=1 within 18 cycles; one EvValid pulse with EvCh=2, EvRise=1. Release later -> one event with EvCh=2, EvRise=0.
3. SwIn[1] toggles 1 for 3 visits, 0 for 1 visit, repeated 5 times (STABLE=4) -> SwOutDB[1] stays 0 and no event occurs.
4. EvReady=0, SwIn[0] and SwIn[3] pressed together -> event EvCh=0, EvRise=1 held stable and ScanIdx frozen for 20 cycles. Raise EvReady for 1 cycle -> EvValid drops. Event EvCh=3 follows within 4*4 cycles.
5. Enable=0 while SwIn[1]=1 for 30 cycles -> no SwOutDB change and ScanIdx constant. Enable=1 -> SwOutDB[1]=1 within 16 cycles.
6. Assert RstN=0 asynchronously while EvValid=1 -> EvValid, SwOutDB, ScanIdx go to 0 immediately without waiting for a clock edge. After release, still-pressed switches re-qualify and regenerate press events.
